switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
Wormhole switch allocator for the 5-port mesh router. It sits between the input buffers and the 5x5 crossbar, and owns the crossbar select lines.
- Arbitrates input requests per output port, round-robin.
- Locks each output to one input from head flit to tail flit.
- Tracks downstream buffer credits per output.
- Drives the one-hot crossbar selects (sel0..sel4) and the per-input grants.

Parameters:
NPORT, 5, number of router ports; fixed at 5, matching the crossbar.
CREDITS, 4, downstream buffer depth per output; credit counter reset value.
CW, 3, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-low reset.
req  in  5  req[i]=1: input i has a flit at its buffer head.
dest0..dest4  in  3 each  encoded destination output of input i's flit (0..4); values 5..7 are illegal.
tail  in  5  tail[i]=1: input i's head flit is the tail (a single-flit packet sets tail on its head).
credit_in  in  5  one-cycle pulse per output k: downstream freed one slot.
grant  out  5  grant[i]=1: input i's flit is transferred this cycle; the input pops it at the next posedge.
sel0..sel4  out  5 each  one-hot input select for crossbar output k; 5'b00000 when idle.
out_valid  out  5  out_valid[k]=1: crossbar output k carries a valid flit this cycle.

Behaviour:
- Reset (rst=0, async): all outputs unlocked; rr_ptr[k]=0; credit[k]=CREDITS; out_valid=0.
  - grant and sel are combinational from cleared state, so they are 0 while rst=0.
- Per-output state machine, 2 states: IDLE, LOCKED(owner).
- Eligibility: input i is eligible for output k when req[i]=1 and dest_i==k. Illegal dest (5..7): input is never eligible.
- IDLE, with credit[k]>0 and at least one eligible input:
  - Winner = first eligible index searching rr_ptr[k], rr_ptr[k]+1, ... modulo 5.
  - grant[w]=1; sel_k=1<<w (same cycle, combinational).
  - At posedge: rr_ptr[k] = (w+1) mod 5.
  - At posedge: if tail[w]=0, go to LOCKED(w); else stay IDLE.
- LOCKED(o):
  - Only input o is considered; other inputs requesting k get no grant.
  - If req[o]=1, dest_o==k and credit[k]>0: grant[o]=1, sel_k=1<<o.
  - On a granted flit with tail[o]=1, go to IDLE at posedge.
  - If req[o] drops (bubble), stay LOCKED and keep sel_k=0.
- An input has only one dest, so it receives at most one grant per cycle. Grants across different outputs are independent.
- Credits, per output:
  - Grant without credit_in: decrement.
  - credit_in without grant: increment, saturating at CREDITS.
  - Grant and credit_in in the same cycle: unchanged.
  - credit[k]==0: no grant to k (not even to the lock owner); state and pointer hold.
- Latency:
  - Request to grant: 0 cycles.
  - Crossbar registers data on the granting posedge.
  - out_valid[k] is registered as (any grant to k) and aligns with crossbar output o_k one cycle after grant.
- Whenever sel_k=0, out_valid[k] is 0 the following cycle. This masks the crossbar's X default output.
- Reset mid-packet: all locks are dropped immediately. The input side is responsible for flushing partial packets.

Decomposition:
- Shared package holds:
  - NPORT.
  - Port index constants: LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
  - State encoding: IDLE=1'b0, LOCKED=1'b1.
  - Function onehot(idx) -> 5-bit.
- Sub-module rr_arbiter_5: 5-bit request vector and 3-bit pointer in, 5-bit one-hot grant out, purely combinational. Instantiated 5 times.
- Lock state, owner register, rr_ptr and credit counter stay in the top level, one per output.

Test Plan:
- Reset, then req=5'b00010, dest1=2, tail[1]=1 -> grant=5'b00010, sel2=5'b00010 same cycle; out_valid[2]=1 next cycle; credit[2]=3.
- Inputs 0,3,4 all to output 1, single-flit, held for 3 cycles from reset -> grants on inputs 0, then 3, then 4; rr_ptr[1] ends at 0.
- Input 2 sends a 3-flit packet to output 0, with input 4 also requesting output 0 -> input 4 gets no grant until the cycle after input 2's tail grant; then sel0=5'b10000.
- CREDITS=4, no credit_in, 5 flits from input 0 to output 3 -> 4 grants, then grant[0]=0. A credit_in[3] pulse gives exactly one more grant.
- Grant and credit_in on the same output in the same cycle -> counter unchanged. credit_in with counter at 4 -> stays 4.
- rst pulled low while output 1 is LOCKED(3) mid-packet -> grant and sel drop at once, out_valid=0; after release, output 1 is IDLE and input 0 can win it.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// Shared definitions for the 5-port wormhole switch allocator.
package switch_allocator_pkg;

    localparam int unsigned NPORT = 5;

    // Router port indices
    localparam logic [2:0] LOCAL = 3'd0;
    localparam logic [2:0] NORTH = 3'd1;
    localparam logic [2:0] EAST  = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] WEST  = 3'd4;

    // Per-output lock state
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic logic [NPORT-1:0] onehot(input logic [2:0] idx);
        return 5'b00001 << idx;
    endfunction

    // Index of the set bit in a one-hot vector; 0 when the vector is empty
    function automatic logic [2:0] onehot_to_idx(input logic [NPORT-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_5.sv
// Combinational 5-way round-robin arbiter: first set request starting at ptr.
module rr_arbiter_5
    import switch_allocator_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic [2:0]       ptr,
    output logic [NPORT-1:0] gnt
);

    // Search ptr, ptr+1, ... modulo 5 and grant the first requester
    always_comb begin
        logic       found;
        logic [3:0] pos;
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        for (int j = 0; j < NPORT; j++) begin
            pos = {1'b0, ptr} + 4'(j);
            if (pos >= 4'd5) pos = pos - 4'd5;
            if (!found && req[pos[2:0]]) begin
                gnt[pos[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration, head-to-tail
// locking and downstream credit tracking; drives crossbar selects and grants.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CW      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic [2:0]       dest0,
    input  logic [2:0]       dest1,
    input  logic [2:0]       dest2,
    input  logic [2:0]       dest3,
    input  logic [2:0]       dest4,
    input  logic [NPORT-1:0] tail,
    input  logic [NPORT-1:0] credit_in,
    output logic [NPORT-1:0] grant,
    output logic [NPORT-1:0] sel0,
    output logic [NPORT-1:0] sel1,
    output logic [NPORT-1:0] sel2,
    output logic [NPORT-1:0] sel3,
    output logic [NPORT-1:0] sel4,
    output logic [NPORT-1:0] out_valid
);

    logic [2:0]       dest     [NPORT];
    logic [NPORT-1:0] arb_req  [NPORT];
    logic [NPORT-1:0] arb_gnt  [NPORT];

    state_e           state_q  [NPORT];
    state_e           state_d  [NPORT];
    logic [2:0]       owner_q  [NPORT];
    logic [2:0]       owner_d  [NPORT];
    logic [2:0]       ptr_q    [NPORT];
    logic [2:0]       ptr_d    [NPORT];
    logic [CW-1:0]    credit_q [NPORT];
    logic [CW-1:0]    credit_d [NPORT];
    logic [NPORT-1:0] out_valid_d;

    assign dest[0] = dest0;
    assign dest[1] = dest1;
    assign dest[2] = dest2;
    assign dest[3] = dest3;
    assign dest[4] = dest4;

    // Eligible requesters per output; a locked output only sees its owner,
    // and nothing is eligible without credit or while reset is held
    always_comb begin
        for (int k = 0; k < NPORT; k++) begin
            arb_req[k] = '0;
            for (int i = 0; i < NPORT; i++) begin
                arb_req[k][i] = req[i] && (dest[i] == 3'(k));
            end
            if (state_q[k] == LOCKED) arb_req[k] = arb_req[k] & onehot(owner_q[k]);
            if (!rst || credit_q[k] == '0) arb_req[k] = '0;
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_arb
        rr_arbiter_5 u_arb (
            .req (arb_req[g]),
            .ptr (ptr_q[g]),
            .gnt (arb_gnt[g])
        );
    end

    assign sel0 = arb_gnt[0];
    assign sel1 = arb_gnt[1];
    assign sel2 = arb_gnt[2];
    assign sel3 = arb_gnt[3];
    assign sel4 = arb_gnt[4];

    // An input targets a single output, so OR-ing the selects gives its grant
    always_comb begin
        grant = '0;
        for (int k = 0; k < NPORT; k++) grant = grant | arb_gnt[k];
    end

    // Next-state: lock/unlock, pointer advance and credit accounting per output
    always_comb begin
        logic       fire;
        logic [2:0] w;
        for (int k = 0; k < NPORT; k++) begin
            state_d[k]     = state_q[k];
            owner_d[k]     = owner_q[k];
            ptr_d[k]       = ptr_q[k];
            credit_d[k]    = credit_q[k];
            fire           = |arb_gnt[k];
            w              = onehot_to_idx(arb_gnt[k]);
            out_valid_d[k] = fire;
            if (fire) begin
                if (state_q[k] == IDLE) begin
                    ptr_d[k] = (w == 3'd4) ? 3'd0 : w + 3'd1;
                    if (!tail[w]) begin
                        state_d[k] = LOCKED;
                        owner_d[k] = w;
                    end
                end else if (tail[w]) begin
                    state_d[k] = IDLE;
                end
            end
            if (fire && !credit_in[k]) begin
                credit_d[k] = credit_q[k] - 1'b1;
            end else if (!fire && credit_in[k] && credit_q[k] < CW'(CREDITS)) begin
                credit_d[k] = credit_q[k] + 1'b1;
            end
        end
    end

    // State registers; reset drops every lock immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NPORT; k++) begin
                state_q[k]  <= IDLE;
                owner_q[k]  <= '0;
                ptr_q[k]    <= '0;
                credit_q[k] <= CW'(CREDITS);
            end
            out_valid <= '0;
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                state_q[k]  <= state_d[k];
                owner_q[k]  <= owner_d[k];
                ptr_q[k]    <= ptr_d[k];
                credit_q[k] <= credit_d[k];
            end
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: one table row per clock cycle plus a
// hand-written asynchronous-reset sequence.
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] req = '0;
    logic [2:0] dest0 = '0, dest1 = '0, dest2 = '0, dest3 = '0, dest4 = '0;
    logic [4:0] tail = '0;
    logic [4:0] credit_in = '0;
    logic [4:0] grant, sel0, sel1, sel2, sel3, sel4, out_valid;

    switch_allocator #(.CREDITS(4), .CW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dest0     (dest0),
        .dest1     (dest1),
        .dest2     (dest2),
        .dest3     (dest3),
        .dest4     (dest4),
        .tail      (tail),
        .credit_in (credit_in),
        .grant     (grant),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .sel4      (sel4),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  req;
        logic [14:0] dest;
        logic [4:0]  tail;
        logic [4:0]  cin;
        logic [4:0]  g;
        logic [24:0] sel;
        logic [4:0]  ov;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [14:0] dst(input logic [2:0] d0, input logic [2:0] d1,
                                        input logic [2:0] d2, input logic [2:0] d3,
                                        input logic [2:0] d4);
        return {d4, d3, d2, d1, d0};
    endfunction

    function automatic logic [24:0] s(input logic [2:0] k, input logic [4:0] v);
        logic [24:0] r;
        r = 25'(v);
        return r << (5 * k);
    endfunction

    task automatic add(input logic r, input logic [4:0] rq, input logic [14:0] d,
                       input logic [4:0] t, input logic [4:0] c, input logic [4:0] g,
                       input logic [24:0] sl, input logic [4:0] ov);
        vec_t v;
        v.rst = r; v.req = rq; v.dest = d; v.tail = t; v.cin = c;
        v.g = g; v.sel = sl; v.ov = ov;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rq, input logic [14:0] d,
                         input logic [4:0] t, input logic [4:0] c);
        rst = r; req = rq; tail = t; credit_in = c;
        {dest4, dest3, dest2, dest1, dest0} = d;
    endtask

    function automatic logic [24:0] sels();
        return {sel4, sel3, sel2, sel1, sel0};
    endfunction

    initial begin
        logic [14:0] d;
        // Single flit input 1 -> output 2, then an illegal destination
        d = dst(0, EAST, 0, 0, 0);
        add(0, 5'b00010, d, 5'b00010, 0, 0, 0, 0);
        add(1, 5'b00010, d, 5'b00010, 0, 5'b00010, s(EAST, 5'b00010), 0);
        add(1, 5'b00000, d, 0, 0, 0, 0, 5'b00100);
        add(1, 5'b00001, dst(5, 0, 0, 0, 0), 5'b00001, 0, 0, 0, 0);
        // Round robin: inputs 0,3,4 to output 1
        d = dst(NORTH, 0, 0, NORTH, NORTH);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 5'b11001, d, 5'b11111, 0, 5'b00001, s(NORTH, 5'b00001), 0);
        add(1, 5'b11001, d, 5'b11111, 0, 5'b01000, s(NORTH, 5'b01000), 5'b00010);
        add(1, 5'b11001, d, 5'b11111, 0, 5'b10000, s(NORTH, 5'b10000), 5'b00010);
        add(1, 5'b11001, d, 5'b11111, 0, 5'b00001, s(NORTH, 5'b00001), 5'b00010);
        // Lock: input 2 three-flit packet to output 0 with a bubble, input 4 waits
        d = dst(0, 0, LOCAL, 0, LOCAL);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 5'b10100, d, 5'b00000, 0, 5'b00100, s(LOCAL, 5'b00100), 0);
        add(1, 5'b10000, d, 5'b10000, 0, 5'b00000, 0, 5'b00001);
        add(1, 5'b10100, d, 5'b10000, 0, 5'b00100, s(LOCAL, 5'b00100), 0);
        add(1, 5'b10100, d, 5'b10100, 0, 5'b00100, s(LOCAL, 5'b00100), 5'b00001);
        add(1, 5'b10000, d, 5'b10000, 0, 5'b10000, s(LOCAL, 5'b10000), 5'b00001);
        add(1, 5'b00000, d, 0, 0, 0, 0, 5'b00001);
        // Credit exhaustion on output 3, one credit_in gives one more grant
        d = dst(SOUTH, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 0);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 5'b01000);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 5'b01000);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 5'b01000);
        add(1, 5'b00001, d, 5'b00001, 0, 0, 0, 5'b01000);
        add(1, 5'b00001, d, 5'b00001, 5'b01000, 0, 0, 0);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 0);
        add(1, 5'b00001, d, 5'b00001, 0, 0, 0, 5'b01000);
        add(1, 5'b00000, d, 0, 0, 0, 0, 0);
        // Grant and credit_in together leave the counter unchanged (stays at 1)
        add(1, 5'b00000, d, 0, 5'b01000, 0, 0, 0);
        add(1, 5'b00001, d, 5'b00001, 5'b01000, 5'b00001, s(SOUTH, 5'b00001), 0);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 5'b01000);
        add(1, 5'b00001, d, 5'b00001, 0, 0, 0, 5'b01000);
        // Saturation: credit_in at a full counter still allows only 4 grants
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 5'b00000, d, 0, 5'b01000, 0, 0, 0);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 0);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 5'b01000);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 5'b01000);
        add(1, 5'b00001, d, 5'b00001, 0, 5'b00001, s(SOUTH, 5'b00001), 5'b01000);
        add(1, 5'b00001, d, 5'b00001, 0, 0, 0, 5'b01000);
        add(1, 5'b00000, d, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].req, vecs[i].dest, vecs[i].tail, vecs[i].cin);
            #1;
            chk($sformatf("row%0d grant", i), 25'(grant), 25'(vecs[i].g));
            chk($sformatf("row%0d sel", i), sels(), vecs[i].sel);
            chk($sformatf("row%0d out_valid", i), 25'(out_valid), 25'(vecs[i].ov));
        end

        // Asynchronous reset while output 1 is LOCKED(3)
        d = dst(NORTH, 0, 0, NORTH, 0);
        @(negedge clk);
        drive(0, 0, d, 0, 0);
        @(negedge clk);
        drive(1, 5'b01000, d, 5'b00000, 0);
        #1;
        chk("lock head grant", 25'(grant), 25'(5'b01000));
        chk("lock head sel", sels(), s(NORTH, 5'b01000));
        @(posedge clk);
        #1;
        chk("locked body grant", 25'(grant), 25'(5'b01000));
        chk("locked out_valid", 25'(out_valid), 25'(5'b00010));
        #1;
        rst = 1'b0;
        req = 5'b01001;
        #1;
        chk("rst grant", 25'(grant), 25'(0));
        chk("rst sel", sels(), 25'(0));
        chk("rst out_valid", 25'(out_valid), 25'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post-rst grant", 25'(grant), 25'(5'b00001));
        chk("post-rst sel", sels(), s(NORTH, 5'b00001));
        chk("post-rst out_valid", 25'(out_valid), 25'(0));
        @(negedge clk);
        drive(1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
